// File: rtl/lemon_pkg.sv
// rtl/lemon_pkg.sv - shared LemonPC core widths and register constants
// Register-file index width, datapath width and the hardwired-zero index.
package lemon_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int X0_IDX     = 0;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]       xword_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for hazard detection
// Writeback clears, issue sets; issue wins because the newer producer owns the register.
module regfile_scoreboard
   import lemon_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int NR_WRITE   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NR_WRITE-1:0]            wen_i,
   input  logic [NR_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
   input  logic                           iss_valid_i,
   input  logic [ADDR_WIDTH-1:0]          iss_rd_i,
   output logic [(1<<ADDR_WIDTH)-1:0]     busy_o
);
   localparam int NREG = 1 << ADDR_WIDTH;

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NR_WRITE; j++) begin
         if (wen_i[j]) begin
            busy_d[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
         end
      end
      if (iss_valid_i) begin
         busy_d[iss_rd_i] = 1'b1;
      end
      busy_d[X0_IDX] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = rst ? '0 : busy_q;
endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-port integer register file with bypass and scoreboard
// Storage, write-port merge, same-cycle forwarding and combinational read muxes.
module regfile_multiport
   import lemon_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH = XLEN,
   parameter int NR_READ    = 2,
   parameter int NR_WRITE   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NR_READ*ADDR_WIDTH-1:0]  rs_addr,
   output logic [NR_READ*DATA_WIDTH-1:0]  rs_data,
   output logic [NR_READ-1:0]             rs_busy,
   input  logic [NR_WRITE-1:0]            wen,
   input  logic [NR_WRITE*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NR_WRITE*DATA_WIDTH-1:0] wr_data,
   input  logic                           iss_valid,
   input  logic [ADDR_WIDTH-1:0]          iss_rd,
   output logic [(1<<ADDR_WIDTH)-1:0]     busy_vec
);
   localparam int NREG = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

   if (NR_READ < 1 || NR_READ > 4 || NR_WRITE < 1 || NR_WRITE > 2) begin : g_bad_params
      $error("regfile_multiport: NR_READ must be 1..4 and NR_WRITE 1..2");
   end

   logic [DATA_WIDTH-1:0] rf_q [NREG];
   logic [DATA_WIDTH-1:0] rf_d [NREG];
   logic [ADDR_WIDTH-1:0] wa [NR_WRITE];
   logic [DATA_WIDTH-1:0] wd [NR_WRITE];

   for (genvar j = 0; j < NR_WRITE; j++) begin : g_wr
      assign wa[j] = wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
   end

   // Higher port index is applied last so it wins a same-address conflict.
   always_comb begin
      rf_d = rf_q;
      for (int j = 0; j < NR_WRITE; j++) begin
         if (wen[j] && wa[j] != X0) begin
            rf_d[wa[j]] = wd[j];
         end
      end
      rf_d[X0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NREG; n++) begin
            rf_q[n] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NR_WRITE   (NR_WRITE)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .wen_i       (wen),
      .wr_addr_i   (wr_addr),
      .iss_valid_i (iss_valid),
      .iss_rd_i    (iss_rd),
      .busy_o      (busy_vec)
   );

   for (genvar i = 0; i < NR_READ; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic                  hit;
      logic [DATA_WIDTH-1:0] hdata;

      assign ra = rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         hit   = 1'b0;
         hdata = '0;
         for (int j = 0; j < NR_WRITE; j++) begin
            if (wen[j] && wa[j] == ra) begin
               hit   = 1'b1;
               hdata = wd[j];
            end
         end
      end

      assign rs_data[i*DATA_WIDTH +: DATA_WIDTH] =
         (rst || ra == X0)       ? '0    :
         (BYPASS != 0 && hit)    ? hdata : rf_q[ra];
      assign rs_busy[i] = !rst && busy_vec[ra] && !(BYPASS != 0 && hit);
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard bench for regfile_multiport, bypass and non-bypass
module tb_regfile_multiport;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rs_addr;
   logic [1:0]  wen;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;

   logic [63:0] rs_data_b, rs_data_n;
   logic [1:0]  rs_busy_b, rs_busy_n;
   logic [31:0] busy_vec_b, busy_vec_n;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_multiport #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .NR_WRITE(2), .BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
      .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy_vec(busy_vec_b));

   regfile_multiport #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .NR_WRITE(2), .BYPASS(0)) u_nobyp (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
      .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy_vec(busy_vec_n));

   // Architectural state of the register file as the spec defines it.
   logic [31:0] m_rf [32];
   logic [31:0] m_busy;

   typedef struct {
      logic [63:0] data_b;
      logic [63:0] data_n;
      logic [1:0]  busy_b;
      logic [1:0]  busy_n;
      logic [31:0] bvec;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic iv, input logic [4:0] ir);
      exp_t e;
      logic [4:0]  a;
      logic        hit;
      logic [31:0] hd;
      logic [4:0]  wa [2];
      logic [31:0] wdv [2];
      wa[0] = wa0; wa[1] = wa1; wdv[0] = wd0; wdv[1] = wd1;
      rst = r; rs_addr = {ra1, ra0}; wen = we; wr_addr = {wa1, wa0};
      wr_data = {wd1, wd0}; iss_valid = iv; iss_rd = ir;
      e.data_b = '0; e.data_n = '0; e.busy_b = '0; e.busy_n = '0;
      for (int i = 0; i < 2; i++) begin
         a = (i == 0) ? ra0 : ra1;
         hit = 1'b0; hd = '0;
         if (we[1] && wa1 == a) begin
            hit = 1'b1; hd = wd1;
         end else if (we[0] && wa0 == a) begin
            hit = 1'b1; hd = wd0;
         end
         if (!r && a != 5'd0) begin
            e.data_n[i*32 +: 32] = m_rf[a];
            e.busy_n[i]          = m_busy[a];
            e.data_b[i*32 +: 32] = hit ? hd : m_rf[a];
            e.busy_b[i]          = hit ? 1'b0 : m_busy[a];
         end
      end
      e.bvec = r ? 32'd0 : m_busy;
      exp_q.push_back(e);
      if (r) begin
         for (int n = 0; n < 32; n++) m_rf[n] = '0;
         m_busy = '0;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j] != 5'd0) m_rf[wa[j]] = wdv[j];
            if (we[j]) m_busy[wa[j]] = 1'b0;
         end
         if (iv) m_busy[ir] = 1'b1;
         m_busy[0] = 1'b0;
      end
   endtask

   task automatic cyc(input logic r, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                      input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic iv, input logic [4:0] ir);
      @(posedge clk);
      #1;
      apply(r, ra0, ra1, we, wa0, wa1, wd0, wd1, iv, ir);
      #1;
   endtask

   // Monitor: outputs are combinational, so every cycle carries one response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rs_data_byp",  64'(rs_data_b),  e.data_b);
            chk("rs_data_nbyp", 64'(rs_data_n),  e.data_n);
            chk("rs_busy_byp",  64'(rs_busy_b),  64'(e.busy_b));
            chk("rs_busy_nbyp", 64'(rs_busy_n),  64'(e.busy_n));
            chk("busy_vec_byp", 64'(busy_vec_b), 64'(e.bvec));
            chk("busy_vec_nbyp", 64'(busy_vec_n), 64'(e.bvec));
         end
      end
   end

   initial begin
      logic [4:0] r0, r1, w0, w1;
      for (int n = 0; n < 32; n++) m_rf[n] = '0;
      m_busy = '0;
      rst = 1'b1; rs_addr = '0; wen = '0; wr_addr = '0; wr_data = '0;
      iss_valid = 1'b0; iss_rd = '0;

      cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("reset_rs_data", rs_data_b, 64'd0);
      cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      // Reset clear: x5 written, then reset with a write/issue to x6 ignored.
      cyc(0, 5, 5, 2'b01, 5, 0, 32'hDEADBEEF, 0, 1, 5);
      cyc(0, 5, 6, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("x5_written", 64'(rs_data_n[31:0]), 64'hDEADBEEF);
      chk("x5_busy_pre_rst", 64'(busy_vec_b[5]), 64'd1);
      cyc(1, 5, 6, 2'b01, 6, 0, 32'h55, 0, 1, 6);
      chk("busy_vec_in_rst", 64'(busy_vec_b), 64'd0);
      cyc(0, 5, 6, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("x5_after_rst", 64'(rs_data_n[31:0]), 64'd0);
      chk("x6_after_rst", 64'(rs_data_n[63:32]), 64'd0);
      chk("busy_after_rst", 64'(busy_vec_n), 64'd0);
      // x0 invariance.
      cyc(0, 0, 0, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 1, 0);
      chk("x0_bypass_read", 64'(rs_data_b[31:0]), 64'd0);
      cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("x0_never_busy", 64'(busy_vec_b[0]), 64'd0);
      chk("x0_stored", 64'(rs_data_n[31:0]), 64'd0);
      // Same-cycle bypass versus registered read.
      cyc(0, 0, 7, 2'b01, 7, 0, 32'h1234, 0, 0, 0);
      chk("bypass_x7", 64'(rs_data_b[63:32]), 64'h1234);
      chk("nobypass_x7_old", 64'(rs_data_n[63:32]), 64'd0);
      cyc(0, 0, 7, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("nobypass_x7_next", 64'(rs_data_n[63:32]), 64'h1234);
      // Scoreboard lifecycle on x3.
      cyc(0, 3, 3, 2'b00, 0, 0, 0, 0, 1, 3);
      chk("x3_busy_same_cycle", 64'(rs_busy_b[0]), 64'd0);
      cyc(0, 3, 3, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("x3_busy_t1", 64'(rs_busy_b[0]), 64'd1);
      cyc(0, 3, 3, 2'b00, 0, 0, 0, 0, 0, 0);
      cyc(0, 3, 3, 2'b00, 0, 0, 0, 0, 0, 0);
      cyc(0, 3, 3, 2'b01, 3, 0, 32'h33, 0, 0, 0);
      chk("x3_wb_byp_busy", 64'(rs_busy_b[0]), 64'd0);
      chk("x3_wb_nbyp_busy", 64'(rs_busy_n[0]), 64'd1);
      cyc(0, 3, 3, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("x3_cleared_t5", 64'(rs_busy_n[0]), 64'd0);
      cyc(0, 3, 3, 2'b01, 3, 0, 32'h44, 0, 1, 3);
      cyc(0, 3, 3, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("x3_set_wins", 64'(rs_busy_n[0]), 64'd1);
      // Dual-write conflict and distinct targets.
      cyc(0, 9, 9, 2'b11, 9, 9, 32'hA, 32'hB, 0, 0);
      chk("dual_conflict_bypass", rs_data_b, {32'hB, 32'hB});
      cyc(0, 9, 10, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("dual_conflict_stored", 64'(rs_data_n[31:0]), 64'hB);
      cyc(0, 9, 10, 2'b11, 9, 10, 32'h1, 32'h2, 0, 0);
      cyc(0, 9, 10, 2'b00, 0, 0, 0, 0, 0, 0);
      chk("dual_distinct", rs_data_n, {32'h2, 32'h1});

      // Random regression; addresses often confined to 0..7 to provoke hits and conflicts.
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(1) == 0) begin
            r0 = 5'($urandom_range(7)); r1 = 5'($urandom_range(7));
            w0 = 5'($urandom_range(7)); w1 = 5'($urandom_range(7));
         end else begin
            r0 = 5'($urandom); r1 = 5'($urandom); w0 = 5'($urandom); w1 = 5'($urandom);
         end
         cyc(($urandom_range(63) == 0), r0, r1, 2'($urandom), w0, w1, $urandom, $urandom,
             ($urandom_range(2) == 0), 5'($urandom_range(7)));
      end

      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
